vec_in_buff: RTL and testbench
==============================

Name: vec_in_buff

Overview:
- Serial-to-parallel vector assembler feeding the output buffer stage's parallel vector/length inputs.
- Accepts a byte-wide stream (e.g. from the UART receiver): one length header word, then that many element words.
- Assembles the elements into an N-entry vector and pulses `done` when the vector is complete.
- Its `out`, `out_len` and `done` connect directly to the downstream buffer's `in`, `in_len` and `set`.

Parameters:
- BITS, 8: element and length-header width in bits.
- N, 8: maximum vector length (number of slots). Must satisfy N <= 2**BITS-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  BITS  incoming stream word (header or element).
- in_valid  input  1  `in` is valid this cycle. Single-cycle strobes; no backpressure.
- out  output  [BITS-1:0] x [N-1:0] (unpacked array)  assembled vector. Index 0 holds the first element.
- out_len  output  BITS  length of the assembled vector.
- done  output  1  one-cycle pulse: `out`/`out_len` hold a complete vector.
- busy  output  1  high while a frame is in progress (header accepted, elements outstanding).
- err  output  1  one-cycle pulse: rejected header (length > N).

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, regardless of state:
  - state=IDLE, all out[i]=0, out_len=0, done=0, busy=0, err=0, internal index=0.
  - Reset mid-frame discards the partial vector.
- All outputs are registered. `done` and `err` are high for exactly one cycle per event.
- Shared package: typedef enum {IDLE, LOAD}.
- IDLE, in_valid=1, in=L:
  - L > N: err=1 next cycle; stay IDLE; out/out_len unchanged.
  - L = 0: out_len=0, all out[i]=0, done=1 next cycle; stay IDLE.
  - 1 <= L <= N: out_len=L, all out[i]=0, idx=0, busy=1; go to LOAD.
- LOAD, in_valid=1: out[idx]=in, idx=idx+1.
  - If idx == L-1: go to IDLE; done=1 and busy=0 in the next cycle.
  - Latency: done is high in the cycle right after the edge that samples the last element. out[L-1] is already valid in that cycle.
- LOAD, in_valid=0: hold all state. There is no timeout.
- Hold rule: out/out_len keep their values after done until the next accepted header clears them. Slots L..N-1 always read 0.
- Back-to-back frames: a header may arrive in the cycle done is high. It is accepted (state is already IDLE). The clear and new out_len take effect at that edge. The downstream stage must latch on done.
- Index counter width is $clog2(N+1). Header comparison uses the full BITS width, with no truncation.
- With in_valid=0 the value on `in` is ignored in every state.

Decomposition:
- Shared package `vec_pkg`:
  - state enum (IDLE, LOAD).
  - localparam defaults for BITS/N shared with the output buffer stage.
- No sub-module. The block is one FSM plus an index counter and the vector register array.

Test Plan:
1. Frame of 3: rst 2 cycles, then in_valid strobes 3, 0x55, 0x33, 0x0F, separated by idle cycles.
   - One cycle after the 0x0F edge: done=1, out_len=3, out[0..2]=0x55,0x33,0x0F, out[3..7]=0, busy=0.
2. Length error: header 9 with N=8.
   - err=1 for one cycle, busy stays 0, out/out_len unchanged.
   - A following header 2 with elements 0xAA, 0xBB completes normally.
3. Zero and full length:
   - Header 0: done=1 one cycle later, out_len=0, all out=0.
   - Header 8 with elements 1..8: done with out[7]=8.
4. Back-to-back: frame 3 (0x55,0x33,0x0F), then header 1 in the same cycle done=1, then element 0x7E.
   - Second done gives out_len=1, out[0]=0x7E, out[1..7]=0.
5. Reset mid-frame: header 4, elements 0x11, 0x22, then rst=1 for one cycle.
   - out all 0, busy=0, no done.
   - A subsequent header 1 with element 0x33 gives done, out[0]=0x33.
6. Integration: chain into the output buffer stage with done->set.
   - Frame 3 (0x55,0x33,0x0F) is reproduced serially on the buffer's out, and its done asserts.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared FSM state type and default vector geometry for the vector assembler and output buffer
package vec_pkg;
    typedef enum logic {IDLE, LOAD} state_t;
    localparam int BITS_DEF = 8;
    localparam int N_DEF = 8;
endpackage

// File: rtl/vec_in_buff.sv
// vec_in_buff: assembles a byte stream (length header, then elements) into a parallel vector
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in, in_valid  : stream word and its single-cycle strobe (no backpressure)
//   out, out_len  : assembled vector (slot 0 = first element) and its length
//   done          : one-cycle pulse when out/out_len hold a complete vector
//   busy          : frame in progress
//   err           : one-cycle pulse when a header exceeds N
module vec_in_buff
    import vec_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int N = N_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] in,
    input  logic            in_valid,
    output logic [BITS-1:0] out [N-1:0],
    output logic [BITS-1:0] out_len,
    output logic            done,
    output logic            busy,
    output logic            err
);
    localparam int IW = $clog2(N + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] len_q, len_d;
    logic [BITS-1:0] vec_q [N-1:0];
    logic [BITS-1:0] vec_d [N-1:0];
    logic            done_q, done_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        vec_d   = vec_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (in_valid && state_q == IDLE) begin
            if (in > BITS'(N)) begin
                err_d = 1'b1;
            end else begin
                // Accepting a header clears the previous vector so unused slots read 0.
                vec_d   = '{default: '0};
                len_d   = in;
                idx_d   = '0;
                done_d  = (in == '0);
                state_d = (in == '0) ? IDLE : LOAD;
            end
        end else if (in_valid && state_q == LOAD) begin
            for (int i = 0; i < N; i++)
                if (32'(idx_q) == i) vec_d[i] = in;
            idx_d = idx_q + 1'b1;
            if (32'(idx_q) + 1 == 32'(len_q)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            vec_q   <= '{default: '0};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out     = vec_q;
    assign out_len = len_q;
    assign done    = done_q;
    assign busy    = (state_q == LOAD);
    assign err     = err_q;
endmodule

// File: tb/tb_vec_in_buff.sv
// tb_vec_in_buff: directed self-checking bench for vec_in_buff
module tb_vec_in_buff;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in = '0;
    logic       in_valid = 1'b0;
    logic [7:0] out [7:0];
    logic [7:0] out_len;
    logic       done, busy, err;
    int         checks = 0;
    int         errors = 0;

    vec_in_buff #(.BITS(8), .N(8)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .out(out), .out_len(out_len), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [7:0] e [8]);
        for (int i = 0; i < 8; i++) chk($sformatf("%s[%0d]", tag, i), 32'(out[i]), 32'(e[i]));
    endtask

    task automatic strobe(input logic [7:0] v);
        in = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in = 8'hFF;
    endtask

    task automatic idle();
        in = 8'hFF;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] e [8];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        e = '{default: 8'h00};
        chk("rst_len", 32'(out_len), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk_vec("rst_out", e);

        strobe(8'd3);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_len", 32'(out_len), 3);
        idle();
        strobe(8'h55);
        idle();
        strobe(8'h33);
        idle();
        strobe(8'h0F);
        chk("t1_done", 32'(done), 1);
        chk("t1_len2", 32'(out_len), 3);
        chk("t1_busy2", 32'(busy), 0);
        e = '{8'h55, 8'h33, 8'h0F, 0, 0, 0, 0, 0};
        chk_vec("t1_out", e);
        idle();
        chk("t1_done_pulse", 32'(done), 0);
        chk_vec("t1_hold", e);

        strobe(8'd9);
        chk("t2_err", 32'(err), 1);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_len", 32'(out_len), 3);
        chk_vec("t2_keep", e);
        idle();
        chk("t2_err_pulse", 32'(err), 0);
        strobe(8'd2);
        strobe(8'hAA);
        chk("t2_nodone", 32'(done), 0);
        strobe(8'hBB);
        chk("t2_done", 32'(done), 1);
        chk("t2_len2", 32'(out_len), 2);
        e = '{8'hAA, 8'hBB, 0, 0, 0, 0, 0, 0};
        chk_vec("t2_out", e);

        strobe(8'd0);
        chk("t3z_done", 32'(done), 1);
        chk("t3z_len", 32'(out_len), 0);
        chk("t3z_busy", 32'(busy), 0);
        e = '{default: 8'h00};
        chk_vec("t3z_out", e);
        strobe(8'd8);
        for (int i = 1; i <= 8; i++) strobe(8'(i));
        chk("t3f_done", 32'(done), 1);
        chk("t3f_len", 32'(out_len), 8);
        e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        chk_vec("t3f_out", e);

        strobe(8'd3);
        strobe(8'h55);
        strobe(8'h33);
        strobe(8'h0F);
        chk("t4_done1", 32'(done), 1);
        strobe(8'd1);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_len", 32'(out_len), 1);
        chk("t4_done_low", 32'(done), 0);
        e = '{default: 8'h00};
        chk_vec("t4_clr", e);
        strobe(8'h7E);
        chk("t4_done2", 32'(done), 1);
        chk("t4_len2", 32'(out_len), 1);
        e = '{8'h7E, 0, 0, 0, 0, 0, 0, 0};
        chk_vec("t4_out", e);

        strobe(8'd4);
        strobe(8'h11);
        strobe(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = '{default: 8'h00};
        chk_vec("t5_out", e);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_len", 32'(out_len), 0);
        idle();
        chk("t5_nodone", 32'(done), 0);
        strobe(8'd1);
        strobe(8'h33);
        chk("t5_done2", 32'(done), 1);
        e = '{8'h33, 0, 0, 0, 0, 0, 0, 0};
        chk_vec("t5_out2", e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
